// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and stream framing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned HDR_BITS       = 8 * HDR_BYTES;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts big-endian bytes into a 32-bit word; word_ready flags the cycle the final byte is accepted.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [23:0] shift;
   logic [1:0]  byte_cnt;

   // On word completion the counter wraps to zero; the next three bytes flush the stale shift contents.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         shift    <= '0;
         byte_cnt <= '0;
      end else if (byte_valid) begin
         shift    <= {shift[15:0], byte_data};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word       = {shift, byte_data};
   assign word_ready = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU in reset while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   state_t state, state_nxt;

   logic [HDR_BITS-1:0] count;
   logic [HDR_BITS-1:0] index;
   logic [HDR_BITS-1:0] n_full;
   logic                asm_valid;
   logic [31:0]         asm_word;
   logic                word_ready;
   logic                last_word;
   logic                in_range;

   assign asm_valid = in_valid && (state == ST_DATA);
   assign n_full    = {count[15:8], in_data};
   assign last_word = (index == count - HDR_BITS'(1));
   assign in_range  = ((32'(index) >> ADDR_W) == 32'd0);

   word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (state == ST_LEN_LO),
      .byte_valid (asm_valid),
      .byte_data  (in_data),
      .word       (asm_word),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LEN_HI;
         ST_LEN_HI: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (n_full == '0) ? ST_DONE : ST_DATA;
         end
         ST_DATA: begin
            in_ready = 1'b1;
            if (word_ready && last_word) state_nxt = ST_DONE;
         end
         ST_DONE:   if (start) state_nxt = ST_LEN_HI;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Index advances at byte acceptance; the strobe is registered so it lands one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         index      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  error <= 1'b0;
                  count <= '0;
                  index <= '0;
               end
            end
            ST_LEN_HI: if (in_valid) count[15:8] <= in_data;
            ST_LEN_LO: begin
               if (in_valid) begin
                  count[7:0] <= in_data;
                  index      <= '0;
                  if (32'(n_full) > (32'd1 << ADDR_W)) error <= 1'b1;
               end
            end
            ST_DATA: begin
               if (word_ready) begin
                  index <= index + HDR_BITS'(1);
                  if (in_range) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= 32'({index, 2'b00});
                     imem_wdata <= asm_word;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign done     = (state == ST_DONE);
   assign cpu_hold = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA) || imem_we;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; a second instance with ADDR_W=2 covers overflow.
module tb_imem_loader;

   logic        clk, reset, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, imem_we, cpu_hold, done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic        in_ready_2, imem_we_2, cpu_hold_2, done_2, error_2;
   logic [31:0] imem_addr_2, imem_wdata_2;

   int checks   = 0;
   int failures = 0;

   logic [31:0] la [64];
   logic [31:0] ld [64];
   logic [31:0] la2 [64];
   logic [31:0] ld2 [64];
   int we_cnt  = 0;
   int we_cnt2 = 0;

   imem_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   imem_loader #(.ADDR_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_2), .imem_we(imem_we_2), .imem_addr(imem_addr_2), .imem_wdata(imem_wdata_2),
      .cpu_hold(cpu_hold_2), .done(done_2), .error(error_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we && we_cnt < 64) begin
         la[we_cnt] = imem_addr;
         ld[we_cnt] = imem_wdata;
         we_cnt++;
      end
      if (imem_we_2 && we_cnt2 < 64) begin
         la2[we_cnt2] = imem_addr_2;
         ld2[we_cnt2] = imem_wdata_2;
         we_cnt2++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, imem_we, cpu_hold, done, error}); end
      checks++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus addr=%h wdata=%h exp=0", imem_addr, imem_wdata); end
   endtask

   task automatic test_basic;
      int base;
      base = we_cnt;
      do_start();
      checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_armed ready=%b hold=%b done=%b exp=1 1 0", in_ready, cpu_hold, done); end
      send(8'h00); send(8'h02);
      send(8'h20); send(8'h08); send(8'h00); send(8'h05);
      send(8'h01); send(8'h09); send(8'h50); send(8'h20);
      checks++; if (imem_we !== 1'b1 || done !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_final_strobe we=%b done=%b hold=%b exp=1 1 1", imem_we, done, cpu_hold); end
      tick(); tick();
      checks++; if (we_cnt - base !== 2) begin failures++; $display("FAIL basic_write_count got=%0d exp=2", we_cnt - base); end
      else begin
         checks++; if (la[base] !== 32'h0 || ld[base] !== 32'h20080005) begin failures++; $display("FAIL basic_w0 addr=%h data=%h exp=00000000 20080005", la[base], ld[base]); end
         checks++; if (la[base+1] !== 32'h4 || ld[base+1] !== 32'h01095020) begin failures++; $display("FAIL basic_w1 addr=%h data=%h exp=00000004 01095020", la[base+1], ld[base+1]); end
      end
      checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || imem_we !== 1'b0) begin failures++; $display("FAIL basic_done done=%b hold=%b ready=%b we=%b exp=1 0 0 0", done, cpu_hold, in_ready, imem_we); end
      checks++; if (imem_addr !== 32'h4 || imem_wdata !== 32'h01095020) begin failures++; $display("FAIL basic_hold_bus addr=%h wdata=%h exp=00000004 01095020", imem_addr, imem_wdata); end
   endtask

   task automatic test_empty;
      int base;
      base = we_cnt;
      do_start();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_cleared got=%b exp=0", done); end
      send(8'h00);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_early got=%b exp=0", done); end
      send(8'h00);
      checks++; if (done !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL empty_done done=%b ready=%b hold=%b exp=1 0 0", done, in_ready, cpu_hold); end
      tick(); tick();
      checks++; if (we_cnt !== base) begin failures++; $display("FAIL empty_no_write got=%0d exp=0", we_cnt - base); end
   endtask

   task automatic test_overflow;
      int base, base2;
      logic [31:0] exp_w [5];
      exp_w = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 32'h20212223};
      base  = we_cnt;
      base2 = we_cnt2;
      do_start();
      send(8'h00); send(8'h05);
      checks++; if (error_2 !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL ovf_error small=%b large=%b exp=1 0", error_2, error); end
      for (int i = 0; i < 20; i++) send(8'(8'h10 + i));
      tick(); tick(); tick();
      checks++; if (we_cnt2 - base2 !== 4) begin failures++; $display("FAIL ovf_small_count got=%0d exp=4", we_cnt2 - base2); end
      else begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (la2[base2+k] !== 32'(k * 4) || ld2[base2+k] !== exp_w[k]) begin failures++; $display("FAIL ovf_small_w%0d addr=%h data=%h exp=%h %h", k, la2[base2+k], ld2[base2+k], 32'(k * 4), exp_w[k]); end
         end
      end
      checks++; if (we_cnt - base !== 5) begin failures++; $display("FAIL ovf_large_count got=%0d exp=5", we_cnt - base); end
      else begin
         checks++; if (la[base+4] !== 32'h10 || ld[base+4] !== exp_w[4]) begin failures++; $display("FAIL ovf_large_w4 addr=%h data=%h exp=00000010 %h", la[base+4], ld[base+4], exp_w[4]); end
      end
      checks++; if (done_2 !== 1'b1 || error_2 !== 1'b1 || cpu_hold_2 !== 1'b0) begin failures++; $display("FAIL ovf_done done=%b err=%b hold=%b exp=1 1 0", done_2, error_2, cpu_hold_2); end
   endtask

   task automatic test_gaps;
      int base;
      logic [7:0] bytes [4];
      bytes = '{8'h8C, 8'h09, 8'h00, 8'h04};
      base = we_cnt;
      do_start();
      checks++; if (error_2 !== 1'b0) begin failures++; $display("FAIL gaps_error_cleared got=%b exp=0", error_2); end
      send(8'h00); tick(); send(8'h01); tick();
      for (int i = 0; i < 4; i++) begin
         send(bytes[i]);
         tick();
      end
      tick();
      checks++; if (we_cnt - base !== 1) begin failures++; $display("FAIL gaps_count got=%0d exp=1", we_cnt - base); end
      else begin
         checks++; if (la[base] !== 32'h0 || ld[base] !== 32'h8C090004) begin failures++; $display("FAIL gaps_word addr=%h data=%h exp=00000000 8c090004", la[base], ld[base]); end
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL gaps_done got=%b exp=1", done); end
   endtask

   task automatic test_reset_mid;
      int base;
      base = we_cnt;
      do_start();
      send(8'h00); send(8'h02);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      send(8'h11); send(8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin failures++; $display("FAIL midreset_outputs flags=%b addr=%h wdata=%h exp=0", {in_ready, imem_we, cpu_hold, done, error}, imem_addr, imem_wdata); end
      tick(); tick();
      checks++; if (we_cnt - base !== 1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", we_cnt - base); end
      else begin
         checks++; if (la[base] !== 32'h0 || ld[base] !== 32'hAABBCCDD) begin failures++; $display("FAIL midreset_w0 addr=%h data=%h exp=00000000 aabbccdd", la[base], ld[base]); end
      end
   endtask

   task automatic test_start_reset;
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL startreset_idle ready=%b hold=%b done=%b exp=0 0 0", in_ready, cpu_hold, done); end
      tick();
      checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL startreset_stays ready=%b hold=%b exp=0 0", in_ready, cpu_hold); end
   endtask

   task automatic test_start_in_data;
      int base;
      base = we_cnt;
      do_start();
      send(8'h00); send(8'h01);
      send(8'h8C);
      start = 1'b1;
      send(8'h09);
      start = 1'b0;
      send(8'h00); send(8'h04);
      tick(); tick();
      checks++; if (we_cnt - base !== 1) begin failures++; $display("FAIL startdata_count got=%0d exp=1", we_cnt - base); end
      else begin
         checks++; if (la[base] !== 32'h0 || ld[base] !== 32'h8C090004) begin failures++; $display("FAIL startdata_word addr=%h data=%h exp=00000000 8c090004", la[base], ld[base]); end
      end
      checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL startdata_done done=%b ready=%b exp=1 0", done, in_ready); end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick();
      test_reset();
      test_basic();
      test_empty();
      test_overflow();
      test_gaps();
      test_reset_mid();
      test_basic();
      test_start_reset();
      test_start_in_data();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
